// File: rtl/avalon_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : avalon_mem_pkg
// Description : Shared types, constants and the power-up fill pattern for the
//               Avalon-MM memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_mem_pkg;

  localparam int WORD_W   = 64;
  localparam int BYTE_CNT = 8;

  // ERR_HOLD is kept for encoding stability; the responder never enters it
  // because protocol errors are only flagged, never stalled on.
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    READY    = 2'd1,
    ERR_HOLD = 2'd2
  } resp_state_t;

  // Preload word for address a: lane k (lane 0 = most significant byte)
  // holds (a*8+k) mod 256, so memory reads back as an incrementing byte ramp.
  function automatic logic [WORD_W-1:0] init_word(input logic [31:0] addr);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < BYTE_CNT; k++) begin
      w[(WORD_W-1-8*k) -: 8] = 8'(addr * 32'd8 + 32'(k));
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_return_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_return_pipe
// Description : LATENCY-deep valid/data shift register carrying read returns.
//               Data is zeroed on entry whenever valid is low, so the output
//               data is zero in every cycle the output valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_return_pipe #(
  parameter int LATENCY = 2,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q [LATENCY];
  logic [DATA_W-1:0] data_q  [LATENCY];

  // First stage captures the accepted read, masking data when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= 1'b0;
      data_q[0]  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
    end
  end

  genvar i;
  generate
    for (i = 1; i < LATENCY; i++) begin : g_stage
      // Each later stage simply follows the one before it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end else begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end
  endgenerate

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_responder
// Description : Avalon-MM slave memory of DEPTH 64-bit words with fixed read
//               latency. After reset the memory is preloaded with a byte ramp
//               (INIT, one word per cycle); commands are then served in READY.
//               Define MEM_WRITE_EN to compile in byte-enabled write support;
//               without it the memory is read-only and writes flag an error.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [WORD_W-1:0] avs_writedata,
  input  logic [7:0]        avs_byteenable,
  output logic [WORD_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              init_done,
  output logic              protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  resp_state_t       state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              w_ready;
  logic              w_oob;
  logic [AW-1:0]     w_idx;
  logic              w_rd_acc;
  logic              w_err_set;
  logic [WORD_W-1:0] w_rd_data;

  assign w_ready = (state_q == READY);
  assign w_oob   = |avs_address[31:AW];
  assign w_idx   = avs_address[AW-1:0];

`ifdef MEM_WRITE_EN
  logic w_wr_acc;
  // A write wins over a simultaneous read; out-of-range writes are dropped
  assign w_wr_acc  = w_ready && avs_write && !w_oob;
  assign w_rd_acc  = w_ready && avs_read && !avs_write;
  assign w_err_set = w_ready && avs_write && (w_oob || avs_read);
`else
  logic unused_wr_bits;
  // Read-only build: every write in READY is a violation, reads proceed
  assign w_rd_acc       = w_ready && avs_read;
  assign w_err_set      = w_ready && avs_write;
  assign unused_wr_bits = ^{avs_writedata, avs_byteenable};
`endif

  assign w_rd_data = w_oob ? '0 : mem_q[w_idx];

  // State register, preload counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: INIT walks every word once, then READY forever
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | w_err_set;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_WORD) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    avs_waitrequest = (state_q != READY);
    init_done       = (state_q == READY);
    protocol_err    = err_q;
  end

  // Memory array: preload pattern in INIT, byte-lane writes in READY
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= init_word(32'(cnt_q));
    end
`ifdef MEM_WRITE_EN
    else if (w_wr_acc) begin
      for (int k = 0; k < BYTE_CNT; k++) begin
        if (avs_byteenable[k]) mem_q[w_idx][8*k +: 8] <= avs_writedata[8*k +: 8];
      end
    end
`endif
  end

  rd_return_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (WORD_W)
  ) u_rd_return_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (w_rd_acc),
    .data_i  (w_rd_data),
    .valid_o (avs_readdatavalid),
    .data_o  (avs_readdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_responder
// Description : Self-checking bench for avalon_mem_responder. A cycle-level
//               reference model (word array + queue of timed returns) predicts
//               every output each cycle under directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [63:0] avs_writedata;
  logic [7:0]  avs_byteenable;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        init_done;
  logic        protocol_err;

  always #5 clk = ~clk;

  avalon_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .init_done         (init_done),
    .protocol_err      (protocol_err)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
  } ret_t;

  logic [63:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_init;
  bit          m_err;
  int          cyc;
  ret_t        m_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reset behaviour: ramp pattern reloaded, returns in flight discarded
  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < 8; k++) begin
        m_mem[a][63-8*k -: 8] = 8'((a * 8 + k) % 256);
      end
    end
    m_ready = 1'b0;
    m_init  = 0;
    m_err   = 1'b0;
    m_q.delete();
  endtask

  // What happens at one rising edge given the commands presented
  task automatic model_edge(input logic rd, input logic wr, input logic [31:0] ad,
                            input logic [63:0] wd, input logic [7:0] be);
    bit in_rng;
    cyc++;
    if (rst) return;
    if (!m_ready) begin
      m_init++;
      if (m_init == DEPTH) m_ready = 1'b1;
      return;
    end
    in_rng = (ad < DEPTH);
`ifdef MEM_WRITE_EN
    if (wr) begin
      if (in_rng) begin
        for (int k = 0; k < 8; k++) if (be[k]) m_mem[int'(ad)][8*k +: 8] = wd[8*k +: 8];
      end else begin
        m_err = 1'b1;
      end
      if (rd) m_err = 1'b1;
    end else if (rd) begin
      m_q.push_back('{cyc + LATENCY - 1, in_rng ? m_mem[int'(ad)] : 64'h0});
    end
`else
    if (wr) m_err = 1'b1;
    if (rd) m_q.push_back('{cyc + LATENCY - 1, in_rng ? m_mem[int'(ad)] : 64'h0});
`endif
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model
  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] ad,
                      input logic [63:0] wd, input logic [7:0] be);
    logic        exp_v;
    logic [63:0] exp_d;
    rst = r; avs_read = rd; avs_write = wr; avs_address = ad;
    avs_writedata = wd; avs_byteenable = be;
    if (r) model_reset();
    @(negedge clk);
    exp_v = 1'b0;
    exp_d = 64'h0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      exp_v = 1'b1;
      exp_d = m_q[0].data;
      void'(m_q.pop_front());
    end
    check_val("waitrequest", {63'b0, avs_waitrequest}, {63'b0, !m_ready});
    check_val("init_done", {63'b0, init_done}, {63'b0, m_ready});
    check_val("protocol_err", {63'b0, protocol_err}, {63'b0, m_err});
    check_val("readdatavalid", {63'b0, avs_readdatavalid}, {63'b0, exp_v});
    check_val("readdata", avs_readdata, exp_d);
    @(posedge clk);
    model_edge(rd, wr, ad, wd, be);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [31:0] r_ad;
    int          sel;
    cyc = 0;
    model_reset();
    rst = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_address = 32'h0;
    avs_writedata = 64'h0; avs_byteenable = 8'h0;
    @(posedge clk); #1;

    // Reset held, then release with a read pending at address 0
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 8'h0);
    idle(3);

    // Back-to-back reads over addresses 0..8
    for (int a = 0; a < 9; a++) step(1'b0, 1'b1, 1'b0, 32'(a), 64'h0, 8'h0);
    idle(4);

    // Out-of-range read, then read+write collision at address 1
    step(1'b0, 1'b1, 1'b0, 32'h20, 64'h0, 8'h0);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 32'h1, 64'h0123_4567_89AB_CDEF, 8'hFF);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 32'h1, 64'h0, 8'h0);
    idle(3);

`ifdef MEM_WRITE_EN
    step(1'b0, 1'b0, 1'b1, 32'h3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    step(1'b0, 1'b1, 1'b0, 32'h3, 64'h0, 8'h0);
    idle(3);
`endif

    // Reset asserted right after two reads are accepted
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    idle(20);
    step(1'b0, 1'b1, 1'b0, 32'h4, 64'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 32'h5, 64'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    idle(20);

`ifndef MEM_WRITE_EN
    step(1'b0, 1'b0, 1'b1, 32'h2, 64'h0, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 32'h2, 64'h0, 8'h0);
    idle(3);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      sel  = int'($urandom_range(0, 9));
      r_ad = (sel < 8) ? 32'($urandom_range(0, DEPTH - 1))
           : (sel == 8) ? (32'h20 | 32'($urandom_range(0, 15))) : $urandom;
      r_rd = ($urandom_range(0, 1) == 1);
      r_wr = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 199) == 0), r_rd, r_wr, r_ad,
           {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
